// File: rtl/neighbor_fifo_to_link.sv
// neighbor_fifo_to_link
//   Receives {increase, old_root} messages from a neighbor FIFO and buffers
//   them in order in a small circular buffer. The local node applies them
//   one per cycle. Applying a message updates the neighbor's root and, at
//   most once per round, marks the neighbor as grown. The block also counts
//   growth contributions from both ends of the edge, up to the edge LENGTH.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   initialize          per-round clear, synchronous, active-high
//   fifo_in_data/valid  incoming message {increase, old_root}
//   fifo_in_ready       message accepted when valid && ready
//   apply_en            permit applying one buffered message this cycle
//   a_increase          local grow request (level; only its rising edge counts)
//   b_old_root_out      root carried by the last applied message
//   b_increase_out      sticky: neighbor has grown along this edge
//   is_fully_grown      growth counter >= LENGTH
//   buf_count           number of buffered messages
//   proto_error         sticky protocol violation (high exactly in ERROR)
//
// Handshake: a message transfers on a rising edge where fifo_in_valid and
// fifo_in_ready are both high. fifo_in_ready depends only on registered
// state and on initialize, never on fifo_in_valid.
module neighbor_fifo_to_link #(
  parameter int LENGTH        = 2,
  parameter int ADDRESS_WIDTH = 12,
  parameter int BUF_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           initialize,
  input  logic [ADDRESS_WIDTH:0]         fifo_in_data,
  input  logic                           fifo_in_valid,
  output logic                           fifo_in_ready,
  input  logic                           apply_en,
  input  logic                           a_increase,
  output logic [ADDRESS_WIDTH-1:0]       b_old_root_out,
  output logic                           b_increase_out,
  output logic                           is_fully_grown,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
  output logic                           proto_error
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int GW = $clog2(LENGTH + 2);

  typedef enum logic {RUN = 1'b0, ERROR = 1'b1} state_t;

  state_t state, state_next;

  logic [ADDRESS_WIDTH:0]   mem [BUF_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic [GW-1:0]            grow_cnt;
  logic [ADDRESS_WIDTH-1:0] root;
  logic                     b_inc;
  logic                     a_prev;

  logic                     push, pop;
  logic                     a_grow, b_grow, dup_grow;
  logic [ADDRESS_WIDTH:0]   head;

  assign head = mem[rd_ptr];

  // No accept and no apply during the initialize cycle: the buffer is being
  // emptied on this edge, so a message taken now would be lost.
  assign fifo_in_ready = (count < CW'(BUF_DEPTH)) && (state == RUN) && !initialize;
  assign push          = fifo_in_valid && fifo_in_ready;
  assign pop           = apply_en && (count != '0) && (state == RUN) && !initialize;

  // A second increase along the same edge is a protocol violation.
  assign b_grow   = pop && head[ADDRESS_WIDTH] && !b_inc;
  assign dup_grow = pop && head[ADDRESS_WIDTH] && b_inc;
  assign a_grow   = a_increase && !a_prev;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dup_grow) state_next = ERROR;
      ERROR:   state_next = ERROR;
      default: state_next = RUN;
    endcase
    if (initialize) state_next = RUN;
  end

  // Buffer storage. It is not cleared: the pointers and count alone decide
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_in_data;
  end

  // Buffer control, applied outputs and growth counter.
  always_ff @(posedge clk) begin
    if (reset || initialize) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      root     <= '0;
      b_inc    <= 1'b0;
      a_prev   <= 1'b0;
      grow_cnt <= '0;
    end else begin
      a_prev <= a_increase;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        root   <= head[ADDRESS_WIDTH-1:0];
        if (b_grow) b_inc <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Saturating: once LENGTH is reached the counter holds. A simultaneous
      // double step from below can land on LENGTH+1.
      if ((state == RUN) && (grow_cnt < GW'(LENGTH)))
        grow_cnt <= grow_cnt + GW'(a_grow) + GW'(b_grow);
    end
  end

  assign b_old_root_out = root;
  assign b_increase_out = b_inc;
  assign is_fully_grown = (grow_cnt >= GW'(LENGTH));
  assign buf_count      = count;
  assign proto_error    = (state == ERROR);

endmodule

// File: doc/neighbor_fifo_to_link.md
NEIGHBOR_FIFO_TO_LINK -- requirements
Module: neighbor_fifo_to_link

Interface
REQ-001 SHALL have parameter LENGTH, default 2, full edge length in half-weight units (>0).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12, root address width.
REQ-003 SHALL have parameter BUF_DEPTH, default 4, receive buffer entries (power of 2, >=2).
REQ-004 SHALL have ports, one per line:
 clk  in  1  clock, all logic on rising edge
 reset  in  1  reset, synchronous, active-high
 initialize  in  1  per-round clear, synchronous, active-high
 fifo_in_data  in  ADDRESS_WIDTH+1  message {increase, old_root} from neighbor FIFO
 fifo_in_valid  in  1  message present
 fifo_in_ready  out  1  this block accepts message this cycle
 apply_en  in  1  node permits applying one buffered message this cycle
 a_increase  in  1  local node grow request, level
 b_old_root_out  out  ADDRESS_WIDTH  last applied neighbor root
 b_increase_out  out  1  neighbor has grown this edge (sticky)
 is_fully_grown  out  1  growth counter >= LENGTH
 buf_count  out  $clog2(BUF_DEPTH+1)  buffered message count
 proto_error  out  1  sticky protocol-violation flag

Function
REQ-005 SHALL accept a message when fifo_in_valid && fifo_in_ready; fifo_in_ready SHALL equal (buf_count < BUF_DEPTH) && state==RUN, combinational on registered state only.
REQ-006 SHALL store accepted messages in order in an internal circular buffer; pointers wrap modulo BUF_DEPTH.
REQ-007 SHALL apply (pop) head entry when apply_en && buf_count>0 && state==RUN; at most one apply per cycle.
REQ-008 Push and pop in same cycle SHALL leave buf_count unchanged; push when full SHALL not occur (ready low); pop when empty SHALL be ignored.
REQ-009 Message arriving into empty buffer SHALL be applicable no earlier than the cycle after acceptance (1-cycle minimum latency, no bypass).
REQ-010 On apply, b_old_root_out SHALL take entry bits [ADDRESS_WIDTH-1:0] on the next edge.
REQ-011 On apply with entry bit ADDRESS_WIDTH=1 and b_increase_out=0, b_increase_out SHALL set and generate a one-cycle b_grow pulse.
REQ-012 On apply with bit ADDRESS_WIDTH=1 while b_increase_out already 1, SHALL set proto_error and enter ERROR; root still updated.
REQ-013 SHALL detect a_increase rising edge (registered previous value) as a_grow pulse; level held high counts once.
REQ-014 Growth counter width $clog2(LENGTH+2); SHALL add a_grow + b_grow each cycle while counter < LENGTH; SHALL hold once >= LENGTH (saturate, no wrap).
REQ-015 Simultaneous a_grow and b_grow SHALL add 2 in one cycle; counter may reach LENGTH+1.
REQ-016 is_fully_grown SHALL be combinational from counter >= LENGTH.
REQ-017 States: RUN, ERROR. RUN->ERROR on REQ-012 condition; ERROR->RUN only on initialize or reset.
REQ-018 In ERROR: fifo_in_ready=0, no applies, counter and outputs frozen, proto_error=1.
REQ-019 initialize SHALL, next edge: empty buffer, clear counter, b_old_root_out=0, b_increase_out=0, a_increase history=0, proto_error=0, state=RUN; fifo_in_ready=0 and no accept/apply during the initialize cycle.
REQ-020 initialize asserted with fifo_in_valid SHALL drop that message (not accepted).

Reset
REQ-021 reset SHALL have priority over initialize and all inputs.
REQ-022 After reset: state=RUN, buf_count=0, fifo_in_ready=1, b_old_root_out=0, b_increase_out=0, is_fully_grown=0 (LENGTH>0), proto_error=0, counter=0.
REQ-023 reset mid-operation SHALL discard buffered messages without applying them.

Verification
REQ-024 Root stream: LENGTH=2, push roots 5,7,9 with apply_en=1 -> b_old_root_out 5,7,9 on consecutive cycles, each one cycle after acceptance, buf_count<=1.
REQ-025 Backpressure: apply_en=0, push 5 messages, BUF_DEPTH=4 -> 4 accepted, fifo_in_ready=0 with buf_count=4; raise apply_en -> ready high next cycle, order preserved, 5th accepted.
REQ-026 Growth: a_increase held high 3 cycles and one increase message applied in same cycle as a_increase rise -> counter=2, is_fully_grown=1 next cycle; further growth leaves counter at 2.
REQ-027 Error: apply two increase messages (roots 3 then 4) -> proto_error=1, b_old_root_out=4, fifo_in_ready=0; initialize -> all outputs zero, RUN.
REQ-028 Simultaneous push+pop at buf_count=2 -> buf_count stays 2 across 10 cycles, pointers wrap correctly (data checked vs. scoreboard).
REQ-029 reset with 3 buffered entries -> buf_count=0, none applied, b_old_root_out=0 next cycle.
